// File: rtl/cpu7_mem_pkg.sv
// Shared types for the data-side SRAM responder: response record, ADE code
// and the address-region check.
package cpu7_mem_pkg;

    localparam int MEM_GRLEN = 32;
    localparam logic [5:0] EXC_ADE = 6'h08;

    typedef struct packed {
        logic [MEM_GRLEN-1:0] rdata;
        logic                 exc;
        logic [5:0]           exccode;
        logic [MEM_GRLEN-1:0] badvaddr;
        logic                 scok;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

    // True when addr falls inside the 2^(aw+2)-byte region starting at base.
    function automatic logic in_region(
        input logic [MEM_GRLEN-1:0] addr,
        input logic [MEM_GRLEN-1:0] base,
        input int unsigned          aw
    );
        logic [MEM_GRLEN-1:0] mask;
        mask = ~((MEM_GRLEN'(1) << (aw + 2)) - MEM_GRLEN'(1));
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/cpu7_resp_fifo.sv
// Small register FIFO holding ordered responses; flush wins over push/pop.
// The head entry reads as zero whenever the FIFO is empty.
module cpu7_resp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop, full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: contents are only visible through a valid head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && wr_ptr_reg == PW'(gi)) mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    assign head  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count = count_reg;

    // The responder throttles acceptance, so a push must always find room.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(do_push && !do_pop && full));

endmodule

// File: rtl/cpu7_data_sram_resp.sv
// Data-side bus responder backed by a single-port synchronous SRAM: ordered
// responses, address-range exceptions and LL/SC reservation tracking.
module cpu7_data_sram_resp
    import cpu7_mem_pkg::*;
#(
    parameter int                   GRLEN = MEM_GRLEN,
    parameter int                   AW    = 14,
    parameter logic [GRLEN-1:0]     BASE  = 32'h1c000000,
    parameter int                   DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [3:0]       data_wstrb,
    input  logic [GRLEN-1:0] data_addr,
    input  logic [GRLEN-1:0] data_wdata,
    input  logic [GRLEN-1:0] data_pc,
    input  logic             data_ll,
    input  logic             data_sc,
    input  logic             data_prefetch,
    input  logic             data_cancel,
    input  logic             data_cancel_ex2,
    input  logic             data_recv,
    output logic             data_addr_ok,
    output logic             data_data_ok_m,
    output logic [GRLEN-1:0] data_rdata_m,
    output logic             data_exception,
    output logic [5:0]       data_exccode,
    output logic [GRLEN-1:0] data_badvaddr,
    output logic             data_scsucceed,
    output logic             data_req_empty,
    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [GRLEN-1:0] ram_wdata,
    input  logic [GRLEN-1:0] ram_rdata
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          inflight_reg;
    logic          pend_load_reg;
    resp_t         pend_reg, pend_next;
    logic          llbit_reg, llbit_next;
    logic [AW-1:0] llbit_addr_reg, llbit_addr_next;

    logic          cancel, accept, do_req, do_ram, in_range, sc_ok, wr_commit;
    logic [AW-1:0] word;
    logic          push, pop, fifo_empty;
    resp_t         push_data, head;
    logic [CW-1:0] fifo_count;
    logic          unused_sig;

    assign unused_sig = ^data_pc;

    assign cancel   = data_cancel | data_cancel_ex2;
    assign in_range = in_region(data_addr, BASE, AW);
    assign word     = data_addr[AW+1:2];

    // Slots already promised (queued or landing next edge) gate acceptance.
    assign data_addr_ok = resetn && ((int'(fifo_count) + int'(inflight_reg)) < DEPTH);
    assign accept       = data_req && data_addr_ok;
    assign do_req       = accept && !data_prefetch;
    assign do_ram       = do_req && in_range;

    assign sc_ok     = data_sc && llbit_reg && (llbit_addr_reg == word);
    assign wr_commit = do_ram && data_wr && (!data_sc || sc_ok);

    assign ram_en    = do_ram;
    assign ram_we    = wr_commit ? data_wstrb : 4'b0000;
    assign ram_addr  = do_ram ? word : '0;
    assign ram_wdata = wr_commit ? data_wdata : '0;

    always_comb begin
        pend_next          = '0;
        pend_next.exc      = !in_range;
        pend_next.exccode  = in_range ? 6'h00 : EXC_ADE;
        pend_next.badvaddr = in_range ? '0 : data_addr;
        pend_next.scok     = in_range && sc_ok;
    end

    // Any SC drops the reservation; a plain store to the reserved word does too.
    always_comb begin
        llbit_next      = llbit_reg;
        llbit_addr_next = llbit_addr_reg;
        if (do_req && data_sc) begin
            llbit_next = 1'b0;
        end else if (do_ram && !data_wr && data_ll) begin
            llbit_next      = 1'b1;
            llbit_addr_next = word;
        end else if (do_ram && data_wr && (word == llbit_addr_reg)) begin
            llbit_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_reg   <= 1'b0;
            pend_load_reg  <= 1'b0;
            pend_reg       <= '0;
            llbit_reg      <= 1'b0;
            llbit_addr_reg <= '0;
        end else begin
            inflight_reg   <= do_req;
            llbit_reg      <= llbit_next;
            llbit_addr_reg <= llbit_addr_next;
            if (do_req) begin
                pend_load_reg <= in_range && !data_wr;
                pend_reg      <= pend_next;
            end
        end
    end

    // Loads pick up SRAM data the cycle after the read; everything else is precomputed.
    always_comb begin
        push_data = pend_reg;
        if (pend_load_reg) push_data.rdata = ram_rdata;
    end

    assign push = inflight_reg && !cancel;
    assign pop  = !fifo_empty && data_recv && !cancel;

    cpu7_resp_fifo #(
        .W     (RESP_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (cancel),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign data_data_ok_m = !fifo_empty;
    assign data_rdata_m   = head.rdata;
    assign data_exception = head.exc;
    assign data_exccode   = head.exccode;
    assign data_badvaddr  = head.badvaddr;
    assign data_scsucceed = head.scok;
    assign data_req_empty = !inflight_reg && fifo_empty;

endmodule

// File: tb/tb_cpu7_data_sram_resp.sv
// Directed bench for cpu7_data_sram_resp with a behavioural byte-write SRAM.
module tb_cpu7_data_sram_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req, data_wr, data_ll, data_sc, data_prefetch;
    logic        data_cancel, data_cancel_ex2, data_recv;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_pc;
    logic        data_addr_ok, data_data_ok_m, data_exception, data_scsucceed, data_req_empty;
    logic [31:0] data_rdata_m, data_badvaddr;
    logic [5:0]  data_exccode;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] sram [0:16383];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= sram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    cpu7_data_sram_resp dut (
        .clk(clk), .resetn(resetn),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_pc(data_pc),
        .data_ll(data_ll), .data_sc(data_sc), .data_prefetch(data_prefetch),
        .data_cancel(data_cancel), .data_cancel_ex2(data_cancel_ex2), .data_recv(data_recv),
        .data_addr_ok(data_addr_ok), .data_data_ok_m(data_data_ok_m),
        .data_rdata_m(data_rdata_m), .data_exception(data_exception),
        .data_exccode(data_exccode), .data_badvaddr(data_badvaddr),
        .data_scsucceed(data_scsucceed), .data_req_empty(data_req_empty),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a, input logic wr, input logic ll, input logic sc,
                       input logic pf, input logic [3:0] strb, input logic [31:0] wd);
        data_req = 1'b1; data_addr = a; data_wr = wr; data_ll = ll; data_sc = sc;
        data_prefetch = pf; data_wstrb = strb; data_wdata = wd;
    endtask

    task automatic idle();
        data_req = 1'b0; data_wr = 1'b0; data_ll = 1'b0; data_sc = 1'b0;
        data_prefetch = 1'b0; data_wstrb = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    initial begin
        resetn = 1'b0; idle(); data_pc = 32'h1c000100; ram_rdata = 32'h0;
        data_cancel = 1'b0; data_cancel_ex2 = 1'b0; data_recv = 1'b0;
        sram[4] = 32'hdeadbeef; sram[5] = 32'h00000055; sram[6] = 32'h00000066;
        sram[7] = 32'h00000077; sram[8] = 32'h00000000; sram[9] = 32'hffffffff;
        sram[10] = 32'h0000aaaa; sram[11] = 32'h0000bbbb; sram[12] = 32'h0000cccc;

        // Reset state, with a request presented to prove it is ignored.
        tick(); tick();
        req(32'h1c000010, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_data_ok_m), 32'd0);
        chk("rst_req_empty", 32'(data_req_empty), 32'd1);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        tick(); idle(); resetn = 1'b1; #1;
        chk("post_rst_addr_ok", 32'(data_addr_ok), 32'd1);

        // Single load with recv held high.
        tick(); data_recv = 1'b1; req(32'h1c000010, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("ld_ram_en", 32'(ram_en), 32'd1);
        chk("ld_ram_addr", 32'(ram_addr), 32'd4);
        tick(); idle();
        chk("ld_not_yet", 32'(data_data_ok_m), 32'd0);
        tick();
        chk("ld_data_ok", 32'(data_data_ok_m), 32'd1);
        chk("ld_rdata", data_rdata_m, 32'hdeadbeef);
        tick();
        chk("ld_empty", 32'(data_req_empty), 32'd1);

        // Back-to-back loads with recv low: acceptance stops at DEPTH.
        data_recv = 1'b0;
        req(32'h1c000014, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("b2b_ok1", 32'(data_addr_ok), 32'd1);
        tick(); data_addr = 32'h1c000018; #1;
        chk("b2b_ok2", 32'(data_addr_ok), 32'd1);
        tick(); data_addr = 32'h1c00001c; #1;
        chk("b2b_stall1", 32'(data_addr_ok), 32'd0);
        tick(); #1;
        chk("b2b_stall2", 32'(data_addr_ok), 32'd0);
        chk("b2b_first", data_rdata_m, 32'h00000055);
        data_recv = 1'b1;
        tick(); #1;
        chk("b2b_third_ok", 32'(data_addr_ok), 32'd1);
        chk("b2b_second", data_rdata_m, 32'h00000066);
        tick(); idle();
        chk("b2b_gap", 32'(data_data_ok_m), 32'd0);
        tick();
        chk("b2b_third", data_rdata_m, 32'h00000077);
        tick();
        chk("b2b_empty", 32'(data_req_empty), 32'd1);

        // Partial store then load back.
        req(32'h1c000024, 1, 0, 0, 0, 4'b0011, 32'h11223344); #1;
        chk("st_ram_we", 32'(ram_we), 32'h3);
        tick(); req(32'h1c000024, 0, 0, 0, 0, 4'h0, 32'h0);
        tick(); idle();
        chk("st_resp_ok", 32'(data_data_ok_m), 32'd1);
        chk("st_resp_rdata", data_rdata_m, 32'h0);
        tick();
        chk("st_readback", data_rdata_m, 32'hffff3344);
        chk("st_mem", sram[9], 32'hffff3344);
        tick();

        // LL then SC (succeeds), then a second SC (fails).
        req(32'h1c000020, 0, 1, 0, 0, 4'h0, 32'h0);
        tick(); idle();
        tick();
        chk("ll_resp_sc", 32'(data_scsucceed), 32'd0);
        req(32'h1c000020, 1, 0, 1, 0, 4'hf, 32'hcafef00d); #1;
        chk("sc1_ram_we", 32'(ram_we), 32'hf);
        tick(); idle();
        tick();
        chk("sc1_succeed", 32'(data_scsucceed), 32'd1);
        chk("sc1_mem", sram[8], 32'hcafef00d);
        req(32'h1c000020, 1, 0, 1, 0, 4'hf, 32'h12345678); #1;
        chk("sc2_ram_we", 32'(ram_we), 32'h0);
        tick(); idle();
        tick();
        chk("sc2_data_ok", 32'(data_data_ok_m), 32'd1);
        chk("sc2_succeed", 32'(data_scsucceed), 32'd0);
        chk("sc2_mem", sram[8], 32'hcafef00d);
        tick();

        // Out-of-range loads raise ADE without touching the SRAM.
        req(32'h00000000, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("ade0_ram_en", 32'(ram_en), 32'd0);
        tick(); req(32'h20000004, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("ade1_ram_en", 32'(ram_en), 32'd0);
        tick(); idle();
        chk("ade0_exc", 32'(data_exception), 32'd1);
        chk("ade0_code", 32'(data_exccode), 32'h08);
        chk("ade0_badv", data_badvaddr, 32'h0);
        tick();
        chk("ade1_code", 32'(data_exccode), 32'h08);
        chk("ade1_badv", data_badvaddr, 32'h20000004);
        tick();
        chk("ade_empty", 32'(data_req_empty), 32'd1);

        // Prefetch is accepted but produces nothing.
        req(32'h1c000010, 0, 0, 0, 1, 4'h0, 32'h0); #1;
        chk("pf_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("pf_ram_en", 32'(ram_en), 32'd0);
        tick(); idle();
        tick();
        chk("pf_no_resp", 32'(data_data_ok_m), 32'd0);
        chk("pf_empty", 32'(data_req_empty), 32'd1);

        // Cancel with one queued and one in flight: nothing delivered.
        data_recv = 1'b0;
        req(32'h1c000028, 0, 0, 0, 0, 4'h0, 32'h0);
        tick(); data_addr = 32'h1c00002c;
        tick(); idle(); data_cancel = 1'b1;
        chk("can_head", data_rdata_m, 32'h0000aaaa);
        tick(); data_cancel = 1'b0;
        chk("can_flushed", 32'(data_data_ok_m), 32'd0);
        chk("can_empty", 32'(data_req_empty), 32'd1);
        tick();
        chk("can_no_late", 32'(data_data_ok_m), 32'd0);

        // Cancel (ex2) beats recv; a load accepted in the cancel cycle survives.
        req(32'h1c000028, 0, 0, 0, 0, 4'h0, 32'h0);
        tick(); idle();
        tick(); data_recv = 1'b1; data_cancel_ex2 = 1'b1;
        req(32'h1c000030, 0, 0, 0, 0, 4'h0, 32'h0); #1;
        chk("can2_accept", 32'(data_addr_ok), 32'd1);
        tick(); idle(); data_cancel_ex2 = 1'b0;
        chk("can2_flushed", 32'(data_data_ok_m), 32'd0);
        chk("can2_inflight", 32'(data_req_empty), 32'd0);
        tick();
        chk("can2_survivor", data_rdata_m, 32'h0000cccc);
        tick();
        chk("can2_empty", 32'(data_req_empty), 32'd1);

        // Asynchronous reset with responses pending.
        data_recv = 1'b0;
        req(32'h1c000010, 0, 0, 0, 0, 4'h0, 32'h0);
        tick(); data_addr = 32'h1c000014;
        tick(); idle();
        chk("pre_rst_data_ok", 32'(data_data_ok_m), 32'd1);
        #1 resetn = 1'b0; #1;
        chk("arst_data_ok", 32'(data_data_ok_m), 32'd0);
        chk("arst_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("arst_req_empty", 32'(data_req_empty), 32'd1);
        tick(); resetn = 1'b1;
        tick(); data_recv = 1'b1;
        chk("arst_no_stale", 32'(data_data_ok_m), 32'd0);
        req(32'h1c000024, 0, 0, 0, 0, 4'h0, 32'h0);
        tick(); idle();
        tick();
        chk("arst_mem_kept", data_rdata_m, 32'hffff3344);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
